dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline MEM port (0) and debug port (1) share one
// synchronous-read memory, one access per three cycles, with bounded port-0 streaks.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and operand capture on the edge leaving it
// ISSUE | memory access driven from captured operands (suppressed if misaligned)
// RESP  | ack/err to the granted port, read data taken from mem_rdata_i
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic              err0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              gnt_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [1:0]        state;
    logic [3:0]        streak;
    logic              gnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              pick1;
    logic              any_req;
    logic              mis;
    logic              resp;
    logic              rd_done;

    // Port 1 wins when alone, or when port 0 has used up its streak allowance.
    assign pick1   = req1_i && (!req0_i || streak == STREAK_MAX);
    assign any_req = req0_i || req1_i;
    assign mis     = addr_q[1:0] != 2'b00;
    assign resp    = state == RESP;
    assign rd_done = resp && !we_q && !mis;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            streak   <= 4'd0;
            gnt      <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req1_i || pick1) begin
                        streak <= 4'd0;
                    end else if (streak != STREAK_MAX) begin
                        streak <= streak + 4'd1;
                    end
                    if (any_req) begin
                        state <= ISSUE;
                        gnt   <= pick1;
                    end
                end
                ISSUE: state <= RESP;
                RESP: begin
                    state <= IDLE;
                    if (rd_done) begin
                        if (gnt) rdata1_q <= mem_rdata_i;
                        else     rdata0_q <= mem_rdata_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands are frozen at grant so requesters may change inputs during the access.
    always_ff @(posedge clk_i) begin
        if (rst_i && state == IDLE && any_req) begin
            we_q    <= pick1 ? we1_i    : we0_i;
            addr_q  <= pick1 ? addr1_i  : addr0_i;
            wdata_q <= pick1 ? wdata1_i : wdata0_i;
        end
    end

    assign busy_o      = state != IDLE;
    assign gnt_o       = gnt;
    assign mem_en_o    = state == ISSUE && !mis;
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign ack0_o = resp && !gnt;
    assign ack1_o = resp && gnt;
    assign err0_o = ack0_o && mis;
    assign err1_o = ack1_o && mis;

    // Read data is visible in RESP itself, then held by the per-port register.
    assign rdata0_o = (rd_done && !gnt) ? mem_rdata_i : rdata0_q;
    assign rdata1_o = (rd_done && gnt)  ? mem_rdata_i : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, fairness/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          ack0, ack1, err0, err1, mem_en, mem_we, busy, gnt;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req0_i(req[0]), .we0_i(we[0]), .addr0_i(addr[0]), .wdata0_i(wdata[0]),
        .ack0_o(ack0), .err0_o(err0), .rdata0_o(rdata0),
        .req1_i(req[1]), .we1_i(we[1]), .addr1_i(addr[1]), .wdata1_i(wdata[1]),
        .ack1_o(ack1), .err1_o(err1), .rdata1_o(rdata1),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .gnt_o(gnt)
    );

    // Synchronous-read memory, 64 words, with a backdoor load path for preloading.
    logic [DW-1:0] ram [64];
    logic          bd_we;
    logic [5:0]    bd_idx;
    logic [DW-1:0] bd_data;
    always @(posedge clk) begin
        if (bd_we) ram[bd_idx] <= bd_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:2]];
        end
    end

    logic [DW-1:0] ref_mem [64];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vt [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bd_write(input int idx, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_idx = 6'(idx); bd_data = d;
        ref_mem[idx] = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit p;
        p = v.port;
        req[p] = 1'b1; we[p] = v.we; addr[p] = v.addr; wdata[p] = v.wdata;
        tick();
        check("vec_busy", busy, 1);
        check("vec_mem_en", mem_en, !v.exp_err);
        check("vec_mem_we", mem_we, v.we && !v.exp_err);
        if (!v.exp_err) begin
            check("vec_mem_addr", mem_addr, v.addr);
            if (v.we) begin
                check("vec_mem_wdata", mem_wdata, v.wdata);
                ref_mem[v.addr[7:2]] = v.wdata;
            end
        end
        tick();
        check("vec_ack", p ? ack1 : ack0, 1);
        check("vec_other_ack", p ? ack0 : ack1, 0);
        check("vec_err", p ? err1 : err0, v.exp_err);
        check("vec_other_err", p ? err0 : err1, 0);
        check("vec_gnt", gnt, p);
        check("vec_rdata", p ? rdata1 : rdata0, v.exp_rdata);
        req[p] = 1'b0;
        tick();
        check("vec_ack_pulse", ack0 | ack1, 0);
        check("vec_idle", busy, 0);
        check("vec_rdata_hold", p ? rdata1 : rdata0, v.exp_rdata);
    endtask

    task automatic wait_ack(output int port, output int cycles);
        cycles = 0;
        port   = -1;
        do begin
            tick();
            cycles++;
        end while (!(ack0 || ack1) && cycles < 10);
        if (ack0) port = 0;
        else if (ack1) port = 1;
    endtask

    task automatic new_req(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = AW'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) addr[p][1:0] = 2'b00;
        wdata[p] = DW'($urandom);
    endtask

    int exp_order [10];

    initial begin
        int port, cyc, total, last;
        int ph, streak, g;
        bit mg, m_we, m_mis;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wd;
        logic [DW-1:0] exp_rd [2];

        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rst_n = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
        end
        tick();
        check("rst_busy", busy, 0);
        check("rst_ack", {ack0, ack1}, 0);
        check("rst_err", {err0, err1}, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_gnt", gnt, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);

        for (int i = 0; i < 64; i++) bd_write(i, 32'h5A00_0000 | DW'(i));
        bd_write(4, 32'hDEAD_BEEF);
        rst_n = 1'b1;
        tick();

        vt[0] = '{0, 0, 32'h10, 32'h0,         0, 32'hDEAD_BEEF};
        vt[1] = '{1, 1, 32'h08, 32'h1234,      0, 32'h0};
        vt[2] = '{1, 0, 32'h08, 32'h0,         0, 32'h1234};
        vt[3] = '{0, 0, 32'h06, 32'h0,         1, 32'hDEAD_BEEF};
        vt[4] = '{0, 1, 32'h20, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF};
        vt[5] = '{1, 0, 32'h20, 32'h0,         0, 32'hCAFE_F00D};
        vt[6] = '{1, 1, 32'h03, 32'h7777,      1, 32'hCAFE_F00D};
        vt[7] = '{0, 0, 32'h0C, 32'h0,         0, 32'h5A00_0003};
        vt[8] = '{1, 0, 32'h11, 32'h0,         1, 32'hCAFE_F00D};
        vt[9] = '{1, 0, 32'hFC, 32'h0,         0, 32'h5A00_003F};
        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        // Operand change during ISSUE must not affect the access.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20;
        tick();
        addr[0] = 32'h40;
        #1;
        check("latch_mem_addr", mem_addr, 32'h20);
        tick();
        check("latch_ack", ack0, 1);
        check("latch_rdata", rdata0, 32'hCAFE_F00D);
        req[0] = 1'b0;
        tick();

        // Both ports held: port 1 gets every fifth slot, acks three cycles apart.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0C;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
        total = 0; last = 0;
        for (int k = 0; k < 10; k++) begin
            wait_ack(port, cyc);
            total += cyc;
            check("fair_port", 64'(port), 64'(exp_order[k]));
            check("fair_spacing", 64'(total - last), (k == 0) ? 64'd2 : 64'd3);
            last = total;
        end
        for (int k = 0; k < 4; k++) begin
            wait_ack(port, cyc);
            check("streak_build", 64'(port), 64'd0);
        end
        rst_n = 1'b0;
        tick();
        check("rst_resp_busy", busy, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(port, cyc);
            check("streak_cleared", 64'(port), 64'(exp_order[k]));
        end

        // Reset during a port-1 ISSUE abandons it; the retry completes normally.
        req[0] = 1'b0;
        tick();
        tick();
        check("abort_issue_gnt", gnt, 1);
        check("abort_issue_en", mem_en, 1);
        rst_n = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_ack", ack1, 0);
        check("abort_mem_en", mem_en, 0);
        check("abort_gnt", gnt, 0);
        rst_n = 1'b1;
        tick();
        check("retry_issue", {busy, mem_en, ack1}, 3'b110);
        tick();
        check("retry_ack", ack1, 1);
        check("retry_rdata", rdata1, 32'hDEAD_BEEF);
        req[1] = 1'b0;
        tick();

        // Randomized run against the transaction-level model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ph = 0; streak = 0; mg = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int c = 0; c < 1500; c++) begin
            m_mis = m_addr[1:0] != 2'b00;
            check("rnd_busy", busy, ph != 0);
            check("rnd_gnt", gnt, mg);
            check("rnd_mem_en", mem_en, ph == 1 && !m_mis);
            check("rnd_mem_we", mem_we, ph == 1 && !m_mis && m_we);
            if (ph == 1 && !m_mis) begin
                check("rnd_mem_addr", mem_addr, m_addr);
                if (m_we) check("rnd_mem_wdata", mem_wdata, m_wd);
            end
            check("rnd_ack0", ack0, ph == 2 && !mg);
            check("rnd_ack1", ack1, ph == 2 && mg);
            check("rnd_err0", err0, ph == 2 && !mg && m_mis);
            check("rnd_err1", err1, ph == 2 && mg && m_mis);
            check("rnd_rdata0", rdata0, exp_rd[0]);
            check("rnd_rdata1", rdata1, exp_rd[1]);

            for (int p = 0; p < 2; p++) begin
                if (req[p] && ph == 2 && int'(mg) == p) begin
                    if ($urandom_range(0, 1) == 1) new_req(p);
                    else req[p] = 1'b0;
                end else if (!req[p] && $urandom_range(0, 2) == 0) begin
                    new_req(p);
                end
            end

            case (ph)
                0: begin
                    if (req[0] || req[1]) begin
                        g = (req[0] && !(req[1] && streak == MS)) ? 0 : 1;
                        if (!req[1] || g == 1) streak = 0;
                        else if (streak < MS) streak = streak + 1;
                        mg = 1'(g); m_we = we[g]; m_addr = addr[g]; m_wd = wdata[g];
                        ph = 1;
                    end else begin
                        streak = 0;
                    end
                end
                1: begin
                    if (m_addr[1:0] == 2'b00) begin
                        if (m_we) ref_mem[m_addr[7:2]] = m_wd;
                        else exp_rd[mg] = ref_mem[m_addr[7:2]];
                    end
                    ph = 2;
                end
                default: ph = 0;
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
